// File: rtl/relogio_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : relogio_pkg
//  Purpose : Shared constants, digit slot indices, continuity FSM state type
//            and a time-of-day successor helper for relogio_johnson_decoder.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package relogio_pkg;

  localparam int SEC_PER_DAY    = 86400;
  localparam int H1_MAX         = 2;
  localparam int H0_MAX_AT_H1_2 = 3;
  localparam int M1_MAX         = 5;
  localparam int S1_MAX         = 5;
  localparam int TOD_W          = 17;

  localparam int NUM_DIG        = 6;
  localparam int DIG_W          = 4;
  localparam int OH_W           = 10;

  // Slot order inside the packed digit vectors; H1 is the top slot so that
  // the five full-width digits occupy a contiguous low range.
  localparam int DIG_S0 = 0;
  localparam int DIG_S1 = 1;
  localparam int DIG_M0 = 2;
  localparam int DIG_M1 = 3;
  localparam int DIG_H0 = 4;
  localparam int DIG_H1 = 5;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } cont_state_t;

  // Next second of the day, wrapping the last second back to midnight.
  function automatic logic [TOD_W-1:0] tod_next(input logic [TOD_W-1:0] i_t);
    return (i_t == TOD_W'(SEC_PER_DAY - 1)) ? '0 : i_t + TOD_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/relogio_johnson_decoder_onehot10_dec.sv
`default_nettype none
// ============================================================================
//  Module  : onehot10_dec
//  Purpose : Maps a 10-bit one-hot digit vector to its 4-bit index and a
//            validity bit (exactly one bit set). Invalid vectors decode to 0.
//  Ports   : i_oh    [9:0] one-hot digit vector
//            o_idx   [3:0] decoded digit value (0 when not valid)
//            o_valid       exactly one bit of i_oh is set
//  Revision: 1.0  initial release
// ============================================================================
module onehot10_dec
  import relogio_pkg::*;
(
  input  logic [OH_W-1:0]  i_oh,
  output logic [DIG_W-1:0] o_idx,
  output logic             o_valid
);

  logic [DIG_W-1:0] w_cnt;
  logic [DIG_W-1:0] w_idx;

  always_comb begin
    w_cnt = '0;
    w_idx = '0;
    for (int k = 0; k < OH_W; k++) begin
      if (i_oh[k]) begin
        w_cnt = w_cnt + DIG_W'(1);
        w_idx = DIG_W'(k);
      end
    end
  end

  assign o_valid = (w_cnt == DIG_W'(1));
  assign o_idx   = o_valid ? w_idx : '0;

endmodule
`default_nettype wire

// File: rtl/relogio_johnson_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : relogio_johnson_decoder
//  Purpose : Decodes six one-hot clock digits (HH:MM:SS) into BCD digits and
//            seconds-since-midnight, flags one-hot/range errors, optionally
//            checks second-to-second continuity, and counts bad samples.
//            Fixed 2-cycle latency, one sample per cycle.
//  Config  : RELOGIO_CONTINUITY_CHECK_EN - when defined, builds the
//            continuity FSM (err_seq, locked); otherwise both are tied low.
//  Ports   : clk, reset (async, active-high)
//            in_valid, h1_oh..s0_oh [9:0]   sample input
//            out_valid                       one-cycle result qualifier
//            h1 [1:0], h0/m1/m0/s1/s0 [3:0]  decoded digits
//            tod_sec [16:0]                  seconds since midnight
//            err_onehot, err_range, err_seq  error flags
//            err_cnt [ERR_CNT_W-1:0]         saturating error count
//            locked                          continuity FSM holds a reference
//  Revision: 1.0  initial release
// ============================================================================
module relogio_johnson_decoder
  import relogio_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [9:0]           h1_oh,
  input  logic [9:0]           h0_oh,
  input  logic [9:0]           m1_oh,
  input  logic [9:0]           m0_oh,
  input  logic [9:0]           s1_oh,
  input  logic [9:0]           s0_oh,
  output logic                 out_valid,
  output logic [1:0]           h1,
  output logic [3:0]           h0,
  output logic [3:0]           m1,
  output logic [3:0]           m0,
  output logic [3:0]           s1,
  output logic [3:0]           s0,
  output logic [16:0]          tod_sec,
  output logic                 err_onehot,
  output logic                 err_range,
  output logic                 err_seq,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked
);

  // --------------------------------------------------------------------------
  // One-hot decode (combinational, ahead of stage 1)
  // --------------------------------------------------------------------------
  logic [NUM_DIG-1:0][OH_W-1:0]  w_oh;
  logic [NUM_DIG-1:0][DIG_W-1:0] w_idx;
  logic [NUM_DIG-1:0]            w_ohv;

  assign w_oh[DIG_H1] = h1_oh;
  assign w_oh[DIG_H0] = h0_oh;
  assign w_oh[DIG_M1] = m1_oh;
  assign w_oh[DIG_M0] = m0_oh;
  assign w_oh[DIG_S1] = s1_oh;
  assign w_oh[DIG_S0] = s0_oh;

  generate
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
      onehot10_dec u_dec (
        .i_oh    (w_oh[g]),
        .o_idx   (w_idx[g]),
        .o_valid (w_ohv[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 1 registers: digit index + per-digit one-hot validity
  // --------------------------------------------------------------------------
  logic                          r_s1_valid;
  logic [NUM_DIG-1:0][DIG_W-1:0] r_s1_idx;
  logic [NUM_DIG-1:0]            r_s1_ohv;

  // --------------------------------------------------------------------------
  // Stage 2 combinational: error classification and seconds-of-day
  // --------------------------------------------------------------------------
  logic             w_err_oh;
  logic             w_err_rng;
  logic [TOD_W-1:0] w_hr;
  logic [TOD_W-1:0] w_mn;
  logic [TOD_W-1:0] w_sc;
  logic [TOD_W-1:0] w_tod_raw;

  assign w_err_oh = ~(&r_s1_ohv);

  // Only digits that decoded cleanly take part in range checks; an invalid
  // digit is already reported through err_onehot.
  assign w_err_rng =
      (r_s1_ohv[DIG_H1] && (r_s1_idx[DIG_H1] > DIG_W'(H1_MAX)))
   || (r_s1_ohv[DIG_H1] && r_s1_ohv[DIG_H0]
       && (r_s1_idx[DIG_H1] == DIG_W'(H1_MAX))
       && (r_s1_idx[DIG_H0] > DIG_W'(H0_MAX_AT_H1_2)))
   || (r_s1_ohv[DIG_M1] && (r_s1_idx[DIG_M1] > DIG_W'(M1_MAX)))
   || (r_s1_ohv[DIG_S1] && (r_s1_idx[DIG_S1] > DIG_W'(S1_MAX)));

  assign w_hr = TOD_W'(r_s1_idx[DIG_H1]) * TOD_W'(10) + TOD_W'(r_s1_idx[DIG_H0]);
  assign w_mn = TOD_W'(r_s1_idx[DIG_M1]) * TOD_W'(10) + TOD_W'(r_s1_idx[DIG_M0]);
  assign w_sc = TOD_W'(r_s1_idx[DIG_S1]) * TOD_W'(10) + TOD_W'(r_s1_idx[DIG_S0]);
  // Raw value may exceed a day for out-of-range inputs; it is zeroed then.
  assign w_tod_raw = w_hr * TOD_W'(3600) + w_mn * TOD_W'(60) + w_sc;

  // Stage 2 registers. H1 is truncated to its 2-bit output width here.
  logic                          r_s2_valid;
  logic [1:0]                    r_s2_h1;
  logic [NUM_DIG-2:0][DIG_W-1:0] r_s2_dig;
  logic                          r_s2_err_oh;
  logic                          r_s2_err_rng;
  logic [TOD_W-1:0]              r_s2_tod;

  // --------------------------------------------------------------------------
  // Continuity check (evaluates the sample leaving stage 2)
  // --------------------------------------------------------------------------
  logic w_s2_err;
  logic w_err_seq;
  logic w_locked;

  assign w_s2_err = r_s2_err_oh | r_s2_err_rng;

`ifdef RELOGIO_CONTINUITY_CHECK_EN
  cont_state_t      r_state;
  cont_state_t      w_state_nxt;
  logic [TOD_W-1:0] r_prev;
  logic [TOD_W-1:0] w_prev_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_UNLOCKED;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_err_seq   = 1'b0;
    if (r_s2_valid) begin
      if (w_s2_err) begin
        w_state_nxt = ST_UNLOCKED;
      end else begin
        case (r_state)
          ST_UNLOCKED: ;
          ST_LOCKED:   w_err_seq = (r_s2_tod != tod_next(r_prev));
          default:     ;
        endcase
        w_prev_nxt  = r_s2_tod;
        w_state_nxt = ST_LOCKED;
      end
    end
  end

  assign w_locked = (r_state == ST_LOCKED);
`else
  assign w_err_seq = 1'b0;
  assign w_locked  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Pipeline and output registers
  // --------------------------------------------------------------------------
  logic                          r_out_valid;
  logic [1:0]                    r_out_h1;
  logic [NUM_DIG-2:0][DIG_W-1:0] r_out_dig;
  logic [TOD_W-1:0]              r_out_tod;
  logic                          r_err_oh;
  logic                          r_err_rng;
  logic                          r_err_seq;
  logic [ERR_CNT_W-1:0]          r_err_cnt;
  logic                          w_any_err;

  assign w_any_err = w_s2_err | w_err_seq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_ohv     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_h1      <= '0;
      r_s2_dig     <= '0;
      r_s2_err_oh  <= 1'b0;
      r_s2_err_rng <= 1'b0;
      r_s2_tod     <= '0;
      r_out_valid  <= 1'b0;
      r_out_h1     <= '0;
      r_out_dig    <= '0;
      r_out_tod    <= '0;
      r_err_oh     <= 1'b0;
      r_err_rng    <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_idx <= w_idx;
        r_s1_ohv <= w_ohv;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_h1      <= r_s1_idx[DIG_H1][1:0];
        r_s2_dig     <= r_s1_idx[NUM_DIG-2:0];
        r_s2_err_oh  <= w_err_oh;
        r_s2_err_rng <= w_err_rng;
        r_s2_tod     <= (w_err_oh || w_err_rng) ? '0 : w_tod_raw;
      end

      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_h1  <= r_s2_h1;
        r_out_dig <= r_s2_dig;
        r_out_tod <= r_s2_tod;
        r_err_oh  <= r_s2_err_oh;
        r_err_rng <= r_s2_err_rng;
        r_err_seq <= w_err_seq;
        if (w_any_err && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign h1         = r_out_h1;
  assign h0         = r_out_dig[DIG_H0];
  assign m1         = r_out_dig[DIG_M1];
  assign m0         = r_out_dig[DIG_M0];
  assign s1         = r_out_dig[DIG_S1];
  assign s0         = r_out_dig[DIG_S0];
  assign tod_sec    = r_out_tod;
  assign err_onehot = r_err_oh;
  assign err_range  = r_err_rng;
  assign err_seq    = r_err_seq;
  assign err_cnt    = r_err_cnt;
  assign locked     = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_relogio_johnson_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_relogio_johnson_decoder
//  Purpose : Self-checking bench for relogio_johnson_decoder. A time-of-day
//            reference model (plain arithmetic on digit values) predicts
//            every output cycle; directed steps plus random samples.
//  Config  : follows RELOGIO_CONTINUITY_CHECK_EN for continuity expectations
//  Revision: 1.0  initial release
// ============================================================================
module tb_relogio_johnson_decoder;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef RELOGIO_CONTINUITY_CHECK_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [9:0]           drv [6];   // 0=h1 1=h0 2=m1 3=m0 4=s1 5=s0
  logic                 out_valid;
  logic [1:0]           h1;
  logic [3:0]           h0, m1, m0, s1, s0;
  logic [16:0]          tod_sec;
  logic                 err_onehot, err_range, err_seq, locked;
  logic [ERR_CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  relogio_johnson_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .h1_oh      (drv[0]),
    .h0_oh      (drv[1]),
    .m1_oh      (drv[2]),
    .m0_oh      (drv[3]),
    .s1_oh      (drv[4]),
    .s0_oh      (drv[5]),
    .out_valid  (out_valid),
    .h1         (h1),
    .h0         (h0),
    .m1         (m1),
    .m0         (m0),
    .s1         (s1),
    .s0         (s0),
    .tod_sec    (tod_sec),
    .err_onehot (err_onehot),
    .err_range  (err_range),
    .err_seq    (err_seq),
    .err_cnt    (err_cnt),
    .locked     (locked)
  );

  typedef struct packed {
    logic             v;
    logic [5:0][3:0]  dg;
    logic             eoh;
    logic             erng;
    logic [16:0]      tod;
  } exp_t;

  exp_t slot_a, slot_b;
  bit   m_locked;
  int   m_prev;
  int   m_cnt;
  int   n_vec = 0;
  int   n_err = 0;
  int   t_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit oh_ok(input logic [9:0] v);
    for (int k = 0; k < 10; k++) if (v == (10'd1 << k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int oh_dig(input logic [9:0] v);
    for (int k = 0; k < 10; k++) if (v == (10'd1 << k)) return k;
    return 0;
  endfunction

  function automatic exp_t model_sample();
    exp_t e;
    int   d [6];
    bit   ok [6];
    bit   all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok[i]  = oh_ok(drv[i]);
      d[i]   = oh_dig(drv[i]);
      all_ok = all_ok & ok[i];
    end
    e.v    = 1'b1;
    e.eoh  = !all_ok;
    e.erng = (ok[0] && d[0] > 2) || (ok[0] && ok[1] && d[0] == 2 && d[1] > 3)
          || (ok[2] && d[2] > 5) || (ok[4] && d[4] > 5);
    for (int i = 0; i < 6; i++) e.dg[i] = 4'(d[i]);
    if (e.eoh || e.erng) e.tod = '0;
    else e.tod = 17'((d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5]);
    return e;
  endfunction

  task automatic model_clear();
    slot_a = '0; slot_b = '0; m_locked = 1'b0; m_prev = 0; m_cnt = 0;
  endtask

  // One clock: advance the model pipeline at the edge, check 1 time unit later.
  task automatic cycle();
    exp_t o;
    bit   seq, err;
    @(posedge clk);
    o      = slot_b;
    slot_b = slot_a;
    slot_a = '0;
    if (reset) begin
      model_clear();
      o = '0;
    end else if (in_valid) begin
      slot_a = model_sample();
    end
    #1;
    seq = 1'b0;
    if (o.v) begin
      err = o.eoh || o.erng;
      if (err) m_locked = 1'b0;
      else if (CONT_EN) begin
        if (m_locked) seq = (int'(o.tod) != (m_prev + 1) % 86400);
        m_prev   = int'(o.tod);
        m_locked = 1'b1;
      end
      if ((err || seq) && m_cnt < CNT_MAX) m_cnt++;
    end
    chk("out_valid", 32'(out_valid), 32'(o.v));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    if (o.v) begin
      chk("h1", 32'(h1), 32'(o.dg[0][1:0]));
      chk("h0", 32'(h0), 32'(o.dg[1]));
      chk("m1", 32'(m1), 32'(o.dg[2]));
      chk("m0", 32'(m0), 32'(o.dg[3]));
      chk("s1", 32'(s1), 32'(o.dg[4]));
      chk("s0", 32'(s0), 32'(o.dg[5]));
      chk("tod_sec", 32'(tod_sec), 32'(o.tod));
      chk("err_onehot", 32'(err_onehot), 32'(o.eoh));
      chk("err_range", 32'(err_range), 32'(o.erng));
      chk("err_seq", 32'(err_seq), 32'(seq));
    end
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    drv[0] = 10'd1 << (hh / 10);
    drv[1] = 10'd1 << (hh % 10);
    drv[2] = 10'd1 << (mm / 10);
    drv[3] = 10'd1 << (mm % 10);
    drv[4] = 10'd1 << (ss / 10);
    drv[5] = 10'd1 << (ss % 10);
  endtask

  task automatic send_cur();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic send(input int hh, input int mm, input int ss);
    set_time(hh, mm, ss);
    send_cur();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t;
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) drv[i] = 10'd1;
    model_clear();
    idle(2);
    chk("rst_tod", 32'(tod_sec), 32'd0);
    chk("rst_flags", 32'({err_onehot, err_range, err_seq}), 32'd0);
    chk("rst_digits", 32'({h1, h0, m1, m0, s1, s0}), 32'd0);
    reset = 1'b0;
    idle(1);

    // Clean 12:34:56
    send(12, 34, 56);
    idle(2);
    chk("tod_123456", 32'(tod_sec), 32'd45296);

    // s0 with two bits set
    set_time(12, 34, 56);
    drv[5] = 10'b0000000011;
    send_cur();
    idle(2);
    chk("onehot_flag", 32'(err_onehot), 32'd1);
    chk("onehot_cnt", 32'(err_cnt), 32'd1);

    // 24:00:00 and 01:60:00 range violations
    set_time(20, 0, 0);
    drv[1] = 10'd1 << 4;
    send_cur();
    set_time(1, 0, 0);
    drv[2] = 10'd1 << 6;
    send_cur();
    idle(2);
    chk("range_m1", 32'(err_range), 32'd1);

    // Midnight wrap, then a skipped second
    send(23, 59, 59);
    send(0, 0, 0);
    idle(2);
    chk("wrap_seq", 32'(err_seq), 32'd0);
    send(10, 0, 0);
    send(10, 0, 2);
    idle(2);
    chk("skip_seq", 32'(err_seq), 32'(CONT_EN));

    // Saturation
    set_time(1, 2, 3);
    drv[5] = 10'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    idle(2);
    chk("sat_cnt", 32'(err_cnt), 32'd255);

    // Random stream
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idle(1);
      end else begin
        if (r <= 6) t = (t_last + 1) % 86400;
        else t = $urandom_range(0, 86399);
        t_last = t;
        set_time(t / 3600, (t / 60) % 60, t % 60);
        if (r == 8) drv[$urandom_range(0, 5)] = 10'($urandom_range(0, 1023));
        if (r == 9) begin
          case ($urandom_range(0, 2))
            0:       drv[0] = 10'd1 << $urandom_range(3, 9);
            1:       drv[2] = 10'd1 << $urandom_range(6, 9);
            default: drv[4] = 10'd1 << $urandom_range(6, 9);
          endcase
        end
        send_cur();
      end
    end

    // Reset with samples in flight
    send(3, 0, 0);
    send(3, 0, 1);
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    set_time(4, 4, 4);
    in_valid = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    send(5, 6, 7);
    idle(1);
    chk("post_rst_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("post_rst_tod", 32'(tod_sec), 32'd18367);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relogio_johnson_decoder.md
RELOGIO_JOHNSON_DECODER -- requirements
Module: relogio_johnson_decoder

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies the six one-hot inputs for sampling on this edge.
REQ-005 h1_oh, h0_oh, m1_oh, m0_oh, s1_oh, s0_oh  input  10 each  one-hot digit vectors; bit k set means digit value k.
REQ-006 out_valid  output  1  one-cycle qualifier for all result outputs.
REQ-007 h1  output  2; h0, m1, m0, s1, s0  output  4 each  decoded BCD digits.
REQ-008 tod_sec  output  17  seconds since midnight, 0..86399.
REQ-009 err_onehot, err_range, err_seq  output  1 each  error flags, qualified by out_valid.
REQ-010 err_cnt  output  ERR_CNT_W  saturating count of erroneous samples.
REQ-011 locked  output  1  continuity checker holds a valid previous sample.

Function
REQ-012 Throughput SHALL be one sample per cycle; no backpressure.
REQ-013 Latency SHALL be 2 cycles: a sample taken at edge N gives out_valid=1 after edge N+2; out_valid=0 otherwise.
REQ-014 Stage 1 SHALL register each digit index and its per-digit one-hot validity (exactly one bit set).
REQ-015 A digit with zero or multiple bits set SHALL decode to 0 and set err_onehot.
REQ-016 err_range SHALL be set if any one-hot-valid digit violates: h1<=2, h1==2 implies h0<=3, m1<=5, s1<=5.
REQ-017 Any range-violating digit SHALL still be output at its decoded value, truncated to the output width for h1.
REQ-018 Stage 2 SHALL compute tod_sec = (h1*10+h0)*3600 + (m1*10+m0)*60 + s1*10 + s0 as unsigned arithmetic without overflow.
REQ-019 If err_onehot or err_range is set, tod_sec SHALL be 0.
REQ-020 The continuity FSM SHALL have states UNLOCKED and LOCKED, and SHALL evaluate only samples with out_valid=1.
REQ-021 In UNLOCKED, a clean sample (no onehot or range error) SHALL store prev=tod_sec and go to LOCKED, with err_seq=0.
REQ-022 In LOCKED, a clean sample SHALL set err_seq=1 iff tod_sec != (prev+1) mod 86400, SHALL update prev, and SHALL stay LOCKED.
REQ-023 The continuity FSM SHALL wrap 86399 to 0 without asserting err_seq.
REQ-024 Any sample with err_onehot or err_range SHALL force UNLOCKED with err_seq=0.
REQ-025 err_cnt SHALL increment by 1 per output sample with any error flag set, and SHALL saturate at all-ones.
REQ-026 locked SHALL equal (state==LOCKED).

Reset
REQ-027 Reset SHALL clear all of the following: out_valid, all digit outputs, tod_sec, all error flags, err_cnt and prev, with state=UNLOCKED.
REQ-028 Reset SHALL flush both pipeline stages, and no out_valid SHALL occur for samples taken before or during reset.
REQ-029 The first sample accepted is the first edge with in_valid=1 after reset deasserts.

Configuration
REQ-030 With macro RELOGIO_CONTINUITY_CHECK_EN defined, the FSM, prev register and err_seq SHALL be implemented per REQ-020..REQ-024.
REQ-031 With RELOGIO_CONTINUITY_CHECK_EN undefined, err_seq and locked SHALL be tied to 0, and err_cnt SHALL count only onehot or range errors.

Structure
REQ-032 Shared package relogio_pkg SHALL hold SEC_PER_DAY=86400, the digit limits (H1_MAX=2, H0_MAX_AT_H1_2=3, M1_MAX=5, S1_MAX=5), TOD_W=17, and the FSM state enum.
REQ-033 One sub-module, onehot10_dec, SHALL map a 10-bit vector to a 4-bit index plus a valid bit, and SHALL be instantiated six times.

Verification
REQ-034 12:34:56 clean one-hot with in_valid -> 2 cycles later out_valid=1, digits 1,2,3,4,5,6, tod_sec=45296, no errors, locked=1.
REQ-035 s0_oh=10'b0000000011 -> err_onehot=1, s0=0, tod_sec=0, err_cnt increments to 1, locked=0.
REQ-036 h1_oh=bit2 with h0_oh=bit4 -> err_range=1, tod_sec=0; separately m1_oh=bit6 -> err_range=1.
REQ-037 Consecutive samples 23:59:59 then 00:00:00 -> tod_sec 86399 then 0, err_seq=0 on both; then 10:00:00 followed by 10:00:02 -> err_seq=1 on the second sample and err_cnt+1.
REQ-038 Drive 300 consecutive bad samples with ERR_CNT_W=8 -> err_cnt holds at 255.
REQ-039 Assert reset mid-stream with samples in flight -> out_valid=0 immediately, err_cnt=0, locked=0, and the first post-reset sample appears exactly 2 cycles after acceptance.
